// File: rtl/debug_dump_tx_pkg.sv
// Shared definitions for the debug dump transmitter: FSM encoding and the
// fixed layout of the 65-word dump (PC, 32 registers, 32 memory words).
package debug_dump_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LATCH,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam int WORD_COUNT     = 65;
  localparam int BYTES_PER_WORD = 4;
  localparam int REG_BASE       = 1;
  localparam int MEM_BASE       = 33;
  localparam int INDEX_WIDTH    = 7;
  localparam int BYTE_CNT_WIDTH = 3;

endpackage

// File: rtl/dump_word_serializer.sv
// Holds one dump word and hands it out a byte at a time, least-significant
// byte first; counts the bytes already shifted out of the current word.
module dump_word_serializer
  import debug_dump_tx_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       load_i,
  input  logic [DATA_WIDTH-1:0]      word_i,
  input  logic                       shift_i,
  output logic [DATA_WIDTH_UART-1:0] byte_o,
  output logic                       last_o
);

  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [BYTE_CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = word_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shift_d = shift_q >> DATA_WIDTH_UART;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign byte_o = shift_q[DATA_WIDTH_UART-1:0];
  // High while the byte on byte_o is the final one of the word.
  assign last_o = (cnt_q == BYTE_CNT_WIDTH'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/debug_dump_tx.sv
// Streams the PC, the register file and the data memory out over a UART,
// one byte per transmit request, under control of a six-state FSM.
module debug_dump_tx
  import debug_dump_tx_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8,
  parameter int ADDR_WIDTH      = 5
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [DATA_WIDTH-1:0]      i_pc,
  output logic [ADDR_WIDTH-1:0]      o_reg_addr,
  input  logic [DATA_WIDTH-1:0]      i_reg_data,
  output logic [ADDR_WIDTH-1:0]      o_mem_addr,
  input  logic [DATA_WIDTH-1:0]      i_mem_data,
  output logic                       o_tx_signal,
  output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
  input  logic                       i_tx_available,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic                       o_done
);

  state_e                       state_q, state_d;
  logic [INDEX_WIDTH-1:0]       index_q, index_d;
  logic [DATA_WIDTH_UART-1:0]   tx_byte_q, tx_byte_d;
  logic                         ser_load, ser_shift, ser_last;
  logic [DATA_WIDTH_UART-1:0]   ser_byte;
  logic [DATA_WIDTH-1:0]        latch_word;
  logic                         is_pc, is_reg;

  assign is_pc  = (index_q == '0);
  assign is_reg = !is_pc && (index_q < INDEX_WIDTH'(MEM_BASE));

  always_comb begin
    latch_word = i_mem_data;
    if (is_pc) begin
      latch_word = i_pc;
    end else if (is_reg) begin
      latch_word = i_reg_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    ser_load    = 1'b0;
    ser_shift   = 1'b0;
    o_tx_signal = 1'b0;
    o_reg_addr  = '0;
    o_mem_addr  = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_LOAD;
          index_d = '0;
        end
      end
      ST_LOAD: begin
        if (is_reg) begin
          o_reg_addr = ADDR_WIDTH'(index_q - INDEX_WIDTH'(REG_BASE));
        end else if (!is_pc) begin
          o_mem_addr = ADDR_WIDTH'(index_q - INDEX_WIDTH'(MEM_BASE));
        end
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (i_tx_available) begin
          o_tx_signal = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          ser_shift = 1'b1;
          if (!ser_last) begin
            state_d = ST_SEND;
          end else if (index_q == INDEX_WIDTH'(WORD_COUNT - 1)) begin
            state_d = ST_DONE;
          end else begin
            index_d = index_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The byte is presented live in the request cycle and held afterwards,
  // since the serializer moves on as soon as the UART reports done.
  assign tx_byte_d = o_tx_signal ? ser_byte : tx_byte_q;
  assign o_tx_byte = tx_byte_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_done = (state_q == ST_DONE);

  dump_word_serializer #(
    .DATA_WIDTH     (DATA_WIDTH),
    .DATA_WIDTH_UART(DATA_WIDTH_UART)
  ) u_serializer (
    .clock_i(i_clock),
    .reset_i(i_reset),
    .load_i (ser_load),
    .word_i (latch_word),
    .shift_i(ser_shift),
    .byte_o (ser_byte),
    .last_o (ser_last)
  );

endmodule

// File: tb/tb_debug_dump_tx.sv
// Directed bench for debug_dump_tx with a registered register-file/memory
// model and a simple UART model that answers each request a few cycles later.
module tb_debug_dump_tx;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pc;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic [4:0]  memAddr;
  logic [31:0] memData;
  logic        txSignal;
  logic [7:0]  txByte;
  logic        txAvailable;
  logic        txDone;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [31:0] regs [32];
  logic [31:0] mems [32];
  logic [7:0]  txBytes [$];
  logic [7:0]  expBytes [$];
  logic [7:0]  firstBytes [$];
  int          doneCount = 0;
  int          busyAfterDoneErr = 0;
  int          busyCnt = 0;
  bit          prevDone = 1'b0;
  bit          uartEnable = 1'b1;

  debug_dump_tx #(
    .DATA_WIDTH     (32),
    .DATA_WIDTH_UART(8),
    .ADDR_WIDTH     (5)
  ) dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_start       (start),
    .i_pc          (pc),
    .o_reg_addr    (regAddr),
    .i_reg_data    (regData),
    .o_mem_addr    (memAddr),
    .i_mem_data    (memData),
    .o_tx_signal   (txSignal),
    .o_tx_byte     (txByte),
    .i_tx_available(txAvailable),
    .i_tx_done     (txDone),
    .o_busy        (busy),
    .o_done        (done)
  );

  always #5 clock = ~clock;

  // Synchronous-read storage: data follows the address by one cycle.
  always @(posedge clock) begin
    regData <= regs[regAddr];
    memData <= mems[memAddr];
  end

  // Byte/done monitor plus UART model; the UART drops available the cycle
  // after a request and pulses done (with available back high) later.
  always @(negedge clock) begin
    if (txSignal) txBytes.push_back(txByte);
    if (done) doneCount++;
    if (prevDone && busy) busyAfterDoneErr++;
    prevDone = done;
    if (uartEnable) begin
      txDone = 1'b0;
      if (txSignal) begin
        busyCnt = 4;
      end else if (busyCnt != 0) begin
        busyCnt--;
        if (busyCnt == 0) begin
          txDone      = 1'b1;
          txAvailable = 1'b1;
        end else begin
          txAvailable = 1'b0;
        end
      end
    end
  end

  function automatic void buildExpected();
    logic [31:0] word;
    expBytes.delete();
    for (int w = 0; w < 65; w++) begin
      if (w == 0) word = pc;
      else if (w <= 32) word = regs[w-1];
      else word = mems[w-33];
      for (int b = 0; b < 4; b++) expBytes.push_back(word[8*b +: 8]);
    end
  endfunction

  function automatic int streamErrors();
    int errs = 0;
    if (txBytes.size() != expBytes.size()) errs++;
    for (int i = 0; i < txBytes.size() && i < expBytes.size(); i++)
      if (txBytes[i] !== expBytes[i]) errs++;
    return errs;
  endfunction

  task automatic pulseStart();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitDone(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clock);
      #1;
      if (doneCount > base) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic waitBytes(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clock);
      #1;
      if (txBytes.size() >= n) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (txSignal !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_signal got=%0b want=0", txSignal); end
    checks++; if (txByte !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_byte got=%h want=00", txByte); end
    checks++; if (regAddr !== 5'd0 || memAddr !== 5'd0) begin failures++; $display("[TB] FAIL reset_addr got=%0d/%0d want=0/0", regAddr, memAddr); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%0b want=0", done); end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_priority_busy got=%0b want=0", busy); end
  endtask

  task automatic test_basic_order();
    int lat;
    int base;
    bit ok;
    pc = 32'h0000_0008;
    buildExpected();
    txBytes.delete();
    base = doneCount;
    @(negedge clock);
    start = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      start = 1'b0;
      #1;
      lat++;
    end while (!txSignal && lat < 50);
    checks++; if (lat < 3 || lat >= 50) begin failures++; $display("[TB] FAIL start_latency got=%0d want>=3", lat); end
    waitDone(base, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL basic_done_timeout got=0 want=1"); end
    @(negedge clock);
    #1;
    checks++; if (txBytes.size() != 260) begin failures++; $display("[TB] FAIL basic_byte_count got=%0d want=260", txBytes.size()); end
    checks++; if ({txBytes[0], txBytes[1], txBytes[2], txBytes[3]} !== 32'h0800_0000) begin failures++; $display("[TB] FAIL pc_bytes got=%h want=08000000", {txBytes[0], txBytes[1], txBytes[2], txBytes[3]}); end
    checks++; if ({txBytes[8], txBytes[9], txBytes[10], txBytes[11]} !== 32'hDDCC_BBAA) begin failures++; $display("[TB] FAIL reg1_bytes got=%h want=ddccbbaa", {txBytes[8], txBytes[9], txBytes[10], txBytes[11]}); end
    checks++; if ({txBytes[132], txBytes[133], txBytes[134], txBytes[135]} !== 32'h4433_2211) begin failures++; $display("[TB] FAIL mem0_bytes got=%h want=44332211", {txBytes[132], txBytes[133], txBytes[134], txBytes[135]}); end
    checks++; if (streamErrors() != 0) begin failures++; $display("[TB] FAIL basic_stream got=%0d_errors want=0", streamErrors()); end
    checks++; if (doneCount - base != 1) begin failures++; $display("[TB] FAIL basic_done_pulses got=%0d want=1", doneCount - base); end
    checks++; if (busyAfterDoneErr != 0) begin failures++; $display("[TB] FAIL busy_after_done got=%0d want=0", busyAfterDoneErr); end
  endtask

  task automatic test_tx_stall();
    int stallErr = 0;
    int base;
    bit ok;
    pc = 32'hCAFE_F00D;
    buildExpected();
    uartEnable  = 1'b0;
    txAvailable = 1'b0;
    txDone      = 1'b0;
    txBytes.delete();
    base = doneCount;
    pulseStart();
    repeat (53) begin
      @(negedge clock);
      #1;
      if (txSignal) stallErr++;
    end
    checks++; if (stallErr != 0 || txBytes.size() != 0) begin failures++; $display("[TB] FAIL stall_no_signal got=%0d want=0", stallErr + txBytes.size()); end
    @(posedge clock);
    #2;
    txAvailable = 1'b1;
    uartEnable  = 1'b1;
    #1;
    checks++; if (txSignal !== 1'b1 || txByte !== 8'h0D) begin failures++; $display("[TB] FAIL stall_release got=%0b/%h want=1/0d", txSignal, txByte); end
    waitDone(base, ok);
    @(negedge clock);
    #1;
    checks++; if (!ok || streamErrors() != 0) begin failures++; $display("[TB] FAIL stall_stream got=%0d_errors want=0", streamErrors()); end
  endtask

  task automatic test_start_ignored();
    int base;
    bit ok;
    pc = 32'h1357_9BDF;
    regs[5] = 32'h0BAD_BEEF;
    mems[31] = 32'h8765_4321;
    buildExpected();
    txBytes.delete();
    base = doneCount;
    pulseStart();
    waitBytes(40, ok);
    pulseStart();
    waitDone(base, ok);
    @(negedge clock);
    #1;
    checks++; if (!ok || txBytes.size() != 260) begin failures++; $display("[TB] FAIL restart_ignored_count got=%0d want=260", txBytes.size()); end
    checks++; if (streamErrors() != 0) begin failures++; $display("[TB] FAIL restart_ignored_stream got=%0d_errors want=0", streamErrors()); end
    checks++; if (doneCount - base != 1) begin failures++; $display("[TB] FAIL restart_ignored_done got=%0d want=1", doneCount - base); end
  endtask

  task automatic test_reset_mid_dump();
    int base;
    bit ok;
    txBytes.delete();
    base = doneCount;
    pulseStart();
    waitBytes(10, ok);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0 || txSignal !== 1'b0) begin failures++; $display("[TB] FAIL midreset_idle got=%0b/%0b want=0/0", busy, txSignal); end
    checks++; if (txByte !== 8'h00 || regAddr !== 5'd0 || memAddr !== 5'd0) begin failures++; $display("[TB] FAIL midreset_outputs got=%h/%0d/%0d want=00/0/0", txByte, regAddr, memAddr); end
    @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    #1;
    checks++; if (doneCount != base || txBytes.size() != 10) begin failures++; $display("[TB] FAIL midreset_quiet got=%0d_done/%0d_bytes want=%0d/10", doneCount, txBytes.size(), base); end
    txBytes.delete();
    pulseStart();
    waitDone(base, ok);
    @(negedge clock);
    #1;
    checks++; if (!ok || streamErrors() != 0) begin failures++; $display("[TB] FAIL midreset_restart got=%0d_errors want=0", streamErrors()); end
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok;
    pc = 32'h0F1E_2D3C;
    buildExpected();
    txBytes.delete();
    base = doneCount;
    pulseStart();
    waitDone(base, ok);
    firstBytes = txBytes;
    txBytes.delete();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waitDone(base + 1, ok);
    @(negedge clock);
    #1;
    checks++; if (!ok || firstBytes.size() != 260 || txBytes.size() != 260) begin failures++; $display("[TB] FAIL b2b_counts got=%0d/%0d want=260/260", firstBytes.size(), txBytes.size()); end
    checks++; if (firstBytes != txBytes) begin failures++; $display("[TB] FAIL b2b_identical got=differs want=identical"); end
    checks++; if (streamErrors() != 0) begin failures++; $display("[TB] FAIL b2b_stream got=%0d_errors want=0", streamErrors()); end
    checks++; if (doneCount - base != 2) begin failures++; $display("[TB] FAIL b2b_done got=%0d want=2", doneCount - base); end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    pc          = '0;
    txAvailable = 1'b1;
    txDone      = 1'b0;
    for (int i = 0; i < 32; i++) begin
      regs[i] = 32'h1000_0000 + i * 32'h0001_0101;
      mems[i] = 32'hF000_0000 - i * 32'h0101_0101;
    end
    regs[1] = 32'hAABB_CCDD;
    mems[0] = 32'h1122_3344;
    test_reset();
    test_basic_order();
    test_tx_stall();
    test_start_ignored();
    test_reset_mid_dump();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
